// File: rtl/fir_fp29i_to_fp16.sv
// Serial FP29i -> IEEE FP16 output converter: bit-serial normalize, RNE round, registered result.
// FP16 subnormal outputs are produced only when FIR_OUT_SUBNORM_EN is defined; otherwise they flush to signed zero.
module fir_fp29i_to_fp16 (
   input  logic        clk_fast,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [29:0] in_fp29i,
   output logic        in_ready,
   output logic        in_drop,
   output logic [15:0] dout,
   output logic        valid,
   output logic        ovf,
   output logic        unf
);
   typedef enum logic [1:0] {IDLE, NORM, DENORM, ROUND} state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_s;
   logic [6:0]         r_e;
   logic [21:0]        r_m;
   logic               r_sticky;
   logic [15:0]        r_dout;
   logic               r_valid;
   logic               r_ovf;
   logic               r_unf;
   logic               r_drop;

   logic signed [7:0]  w_e16;
   logic               w_flush;
   logic               w_denorm;
   logic               w_inc;
   logic [4:0]         w_exp5;
   logic [14:0]        w_sum;
   logic [15:0]        w_dout;
   logic               w_ovf;
   logic               w_unf;

   assign w_e16 = $signed({1'b0, r_e}) - 8'sd48;

`ifdef FIR_OUT_SUBNORM_EN
   logic r_flush;
   logic r_denorm;
   assign w_flush  = r_flush;
   assign w_denorm = r_denorm;
`else
   assign w_flush  = (w_e16 < 8'sd1);
   assign w_denorm = 1'b0;
`endif

   // Round-to-nearest-even; a fraction carry ripples into the exponent field.
   assign w_inc  = r_m[10] & ((|r_m[9:0]) | r_sticky | r_m[11]);
   assign w_exp5 = w_denorm ? 5'd0 : w_e16[4:0];
   assign w_sum  = {w_exp5, r_m[20:11]} + {14'd0, w_inc};

   always_comb begin
      w_dout = {r_s, 15'h0000};
      w_ovf  = 1'b0;
      w_unf  = 1'b0;
      if (r_m == 22'd0) begin
         w_unf = 1'b0;
      end else if (w_flush) begin
         w_unf = 1'b1;
      end else if ((!w_denorm && (w_e16 >= 8'sd31)) || (w_sum[14:10] == 5'h1F)) begin
         w_dout = {r_s, 15'h7C00};
         w_ovf  = 1'b1;
      end else begin
         w_dout = {r_s, w_sum};
         w_unf  = w_denorm && (w_sum[14:10] == 5'd0);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (in_valid) w_next = NORM;
         NORM: begin
            if (r_m == 22'd0) begin
               w_next = ROUND;
            end else if (r_m[21] || (r_e == 7'd0)) begin
`ifdef FIR_OUT_SUBNORM_EN
               w_next = ((r_e >= 7'd38) && (r_e <= 7'd48)) ? DENORM : ROUND;
`else
               w_next = ROUND;
`endif
            end
         end
`ifdef FIR_OUT_SUBNORM_EN
         DENORM: if (r_e == 7'd48) w_next = ROUND;
`endif
         ROUND: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         r_s      <= 1'b0;
         r_e      <= 7'd0;
         r_m      <= 22'd0;
         r_sticky <= 1'b0;
         r_dout   <= 16'h0000;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_drop   <= 1'b0;
`ifdef FIR_OUT_SUBNORM_EN
         r_flush  <= 1'b0;
         r_denorm <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         r_drop  <= in_valid && (r_state != IDLE);
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_s      <= in_fp29i[29];
                  r_e      <= in_fp29i[28:22];
                  r_m      <= in_fp29i[21:0];
                  r_sticky <= 1'b0;
`ifdef FIR_OUT_SUBNORM_EN
                  r_flush  <= 1'b0;
                  r_denorm <= 1'b0;
`endif
               end
            end
            NORM: begin
               if ((r_m != 22'd0) && !r_m[21] && (r_e != 7'd0)) begin
                  r_m <= r_m << 1;
                  r_e <= r_e - 7'd1;
               end
`ifdef FIR_OUT_SUBNORM_EN
               // More than 11 right shifts would leave nothing above the guard bit.
               else if ((r_m != 22'd0) && (r_e <= 7'd48)) begin
                  if (r_e < 7'd38) r_flush  <= 1'b1;
                  else             r_denorm <= 1'b1;
               end
`endif
            end
`ifdef FIR_OUT_SUBNORM_EN
            DENORM: begin
               r_m      <= r_m >> 1;
               r_sticky <= r_sticky | r_m[0];
               r_e      <= r_e + 7'd1;
            end
`endif
            ROUND: begin
               r_dout  <= w_dout;
               r_ovf   <= w_ovf;
               r_unf   <= w_unf;
               r_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready = (r_state == IDLE);
   assign in_drop  = r_drop;
   assign dout     = r_dout;
   assign valid    = r_valid;
   assign ovf      = r_ovf;
   assign unf      = r_unf;
endmodule

// File: tb/tb_fir_fp29i_to_fp16.sv
// Bench for fir_fp29i_to_fp16: directed cases plus random inputs checked against an exact-value RNE model.
module tb_fir_fp29i_to_fp16;
   logic        clk_fast = 1'b0;
   logic        rst_n    = 1'b0;
   logic        in_valid = 1'b0;
   logic [29:0] in_fp29i = '0;
   logic        in_ready;
   logic        in_drop;
   logic [15:0] dout;
   logic        valid;
   logic        ovf;
   logic        unf;

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   int acc_cyc = 0;

   always #5 clk_fast = ~clk_fast;
   always @(posedge clk_fast) cyc <= cyc + 1;

   fir_fp29i_to_fp16 dut (
      .clk_fast (clk_fast),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_fp29i (in_fp29i),
      .in_ready (in_ready),
      .in_drop  (in_drop),
      .dout     (dout),
      .valid    (valid),
      .ovf      (ovf),
      .unf      (unf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Exact value m*2^(e-84) rounded to FP16 (RNE); lat counts clock edges after the accept edge.
   task automatic model(input logic s, input int e, input int m,
                        output logic [15:0] d, output logic ov, output logic un, output int lat);
      int p, k, en, dd, q, sh, lg;
      longint n, rem, half, one, bits;
      one = 1;
      ov  = 1'b0;
      un  = 1'b0;
      d   = {s, 15'h0000};
      if (m == 0) begin
         lat = 2;
         return;
      end
      p = 21;
      while (((m >> p) & 1) == 0) p--;
      k  = (21 - p < e) ? 21 - p : e;
      en = e - k;
      dd = 0;
`ifdef FIR_OUT_SUBNORM_EN
      if (en >= 38 && en <= 48) dd = 49 - en;
`endif
      lat = 2 + k + dd;
      lg  = p + e - 84;
      q   = ((lg > -14) ? lg : -14) - 10;
      sh  = e - 84 - q;
      if (sh >= 0) begin
         n = longint'(m) << sh;
      end else begin
         n    = longint'(m) >> (-sh);
         rem  = longint'(m) & ((one << (-sh)) - 1);
         half = one << (-sh - 1);
         if (rem > half || (rem == half && n[0])) n = n + 1;
      end
      bits = longint'(q + 24) * 1024 + n;
`ifndef FIR_OUT_SUBNORM_EN
      if (lg < -14) begin
         un = 1'b1;
         return;
      end
`endif
      if (bits >= 64'h7C00) begin
         d  = {s, 15'h7C00};
         ov = 1'b1;
      end else begin
         d  = {s, bits[14:0]};
         un = (bits < 1024);
      end
   endtask

   task automatic start(input logic s, input int e, input int m);
      @(negedge clk_fast);
      in_valid = 1'b1;
      in_fp29i = {s, e[6:0], m[21:0]};
      @(posedge clk_fast);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic [15:0] ed, input logic eo,
                              input logic eu, input int elat);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk_fast);
         #1;
         if (valid) begin
            got = 1'b1;
            break;
         end
      end
      chk({tag, " valid_seen"}, 32'(got), 32'd1);
      if (got) begin
         chk({tag, " latency"}, 32'(cyc - acc_cyc), 32'(elat));
         chk({tag, " dout"}, 32'(dout), 32'(ed));
         chk({tag, " ovf"}, 32'(ovf), 32'(eo));
         chk({tag, " unf"}, 32'(unf), 32'(eu));
         chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
         @(posedge clk_fast);
         #1;
         chk({tag, " valid_pulse"}, 32'(valid), 32'd0);
      end
   endtask

   task automatic conv(input string tag, input logic s, input int e, input int m,
                       input logic [15:0] ed, input logic eo, input logic eu, input int elat);
      start(s, e, m);
      wait_result(tag, ed, eo, eu, elat);
   endtask

   initial begin
      logic [15:0] md;
      logic        mo, mu, rs, seen;
      int          ml, re, rm;

      #1;
      chk("rst dout", 32'(dout), 32'h0);
      chk("rst valid", 32'(valid), 32'd0);
      chk("rst ovf", 32'(ovf), 32'd0);
      chk("rst unf", 32'(unf), 32'd0);
      chk("rst in_drop", 32'(in_drop), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      repeat (3) @(negedge clk_fast);
      rst_n = 1'b1;

      // valid lands in cycle A+3+k+d, i.e. 2+k+d edges after the accept edge
      conv("one",       1'b0, 63, 22'h200000, 16'h3C00, 1'b0, 1'b0, 2);
      conv("maxshift",  1'b0, 84, 22'h000001, 16'h3C00, 1'b0, 1'b0, 23);
      conv("tie_even",  1'b0, 63, 22'h200400, 16'h3C00, 1'b0, 1'b0, 2);
      conv("tie_odd",   1'b0, 63, 22'h200C00, 16'h3C02, 1'b0, 1'b0, 2);
      conv("neg1p5",    1'b1, 63, 22'h300000, 16'hBE00, 1'b0, 1'b0, 2);
      conv("ovf",       1'b0, 79, 22'h200000, 16'h7C00, 1'b1, 1'b0, 2);
      conv("ovf_round", 1'b1, 78, 22'h3FFFFF, 16'hFC00, 1'b1, 1'b0, 2);
      conv("e127",      1'b0, 127, 22'h000001, 16'h7C00, 1'b1, 1'b0, 23);
`ifdef FIR_OUT_SUBNORM_EN
      conv("subnorm",   1'b0, 48, 22'h200000, 16'h0200, 1'b0, 1'b1, 3);
      conv("minsub",    1'b0, 38, 22'h200000, 16'h0000, 1'b0, 1'b1, 13);
      conv("minsub_up", 1'b0, 38, 22'h200001, 16'h0001, 1'b0, 1'b1, 13);
`else
      conv("subnorm",   1'b0, 48, 22'h200000, 16'h0000, 1'b0, 1'b1, 2);
`endif
      conv("deep_tiny", 1'b1, 20, 22'h200000, 16'h8000, 1'b0, 1'b1, 2);
      conv("neg_zero",  1'b1, 63, 22'h000000, 16'h8000, 1'b0, 1'b0, 2);

      // second request while busy is dropped; first result unaffected
      start(1'b0, 84, 22'h000001);
      @(negedge clk_fast);
      @(negedge clk_fast);
      in_valid = 1'b1;
      in_fp29i = {1'b1, 7'd70, 22'h3FFFFF};
      @(posedge clk_fast);
      #1;
      in_valid = 1'b0;
      chk("drop pulse", 32'(in_drop), 32'd1);
      @(posedge clk_fast);
      #1;
      chk("drop single", 32'(in_drop), 32'd0);
      wait_result("drop_first", 16'h3C00, 1'b0, 1'b0, 23);

      // reset mid-NORM aborts with no valid and clears dout
      start(1'b0, 84, 22'h000001);
      repeat (4) @(posedge clk_fast);
      @(negedge clk_fast);
      rst_n = 1'b0;
      #1;
      chk("midrst dout", 32'(dout), 32'h0);
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      @(negedge clk_fast);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk_fast);
         #1;
         if (valid) seen = 1'b1;
      end
      chk("midrst no_valid", 32'(seen), 32'd0);

      for (int i = 0; i < 200; i++) begin
         rs = 1'($urandom_range(1, 0));
         re = ($urandom_range(1, 0) == 1) ? int'($urandom_range(127, 0)) : int'($urandom_range(90, 30));
         rm = int'($urandom & 32'h3FFFFF) >> $urandom_range(21, 0);
         model(rs, re, rm, md, mo, mu, ml);
         conv($sformatf("rnd%0d e=%0d m=%0h", i, re, rm), rs, re, rm, md, mo, mu, ml);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
